irq_ctrl: RTL and testbench

Machine-mode interrupt/exception arbiter for the multicycle RV32 core; sits directly upstream of the CSR file. Synchronises the external interrupt, owns the software-interrupt bit and the machine timer (mtime/mtimecmp), and presents mip to the CSR file. Merges core exceptions with enabled interrupts and issues a single-cycle trap_pending pulse with trap_cause, which the CSR file and the core consume.

---
 rtl/irq_ctrl.sv | 158 +++++++++++++++
 tb/tb_irq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt/exception arbiter: external-IRQ synchroniser, msip, optional timer,
// mip presentation and single-cycle trap strobe. Timer is built only with IRQ_CTRL_TIMER_EN defined.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        instr_boundary,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] mie,
  input  logic        irq_en,
  output logic [31:0] mip,
  output logic        trap_pending,
  output logic [31:0] trap_cause,
  output logic        double_trap,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata
);

  typedef enum logic {IDLE, ISSUE} state_t;

  if (SYNC_STAGES < 2 || TIMER_DIV < 1) begin : g_bad_param
    $error("irq_ctrl: SYNC_STAGES must be >= 2 and TIMER_DIV >= 1");
  end

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_msip;
  logic [31:0]            r_mip;
  logic                   r_trap_pending;
  logic [31:0]            r_trap_cause;
  logic                   r_double_trap;
  logic                   w_wr;
  logic                   w_mtip;
  logic [31:0]            w_irq;
  logic                   w_irq_any;
  logic [4:0]             w_code;
  logic                   w_unused;

  assign w_wr     = bus_sel & bus_we;
  assign w_unused = ^{mie, bus_wdata[31:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_msip <= 1'b0;
      r_mip  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_ext};
      if (w_wr && bus_addr == 5'h00) r_msip <= bus_wdata[0];
      r_mip <= {20'b0, r_sync[SYNC_STAGES-1], 3'b0, w_mtip, 3'b0, r_msip, 3'b0};
    end
  end

`ifdef IRQ_CTRL_TIMER_EN
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (32'(r_presc) == 32'(TIMER_DIV - 1));
  assign w_mtip = (r_mtime >= r_mtimecmp);

  // A software write to mtime overrides the tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_presc    <= '0;
    end else begin
      if (w_wr && bus_addr == 5'h04) begin
        r_mtime[31:0] <= bus_wdata;
        r_presc       <= '0;
      end else if (w_wr && bus_addr == 5'h08) begin
        r_mtime[63:32] <= bus_wdata;
        r_presc        <= '0;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_wr && bus_addr == 5'h0C) r_mtimecmp[31:0]  <= bus_wdata;
      if (w_wr && bus_addr == 5'h10) r_mtimecmp[63:32] <= bus_wdata;
    end
  end
`else
  assign w_mtip = 1'b0;
`endif

  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      case (bus_addr)
        5'h00: bus_rdata = {31'b0, r_msip};
`ifdef IRQ_CTRL_TIMER_EN
        5'h04: bus_rdata = r_mtime[31:0];
        5'h08: bus_rdata = r_mtime[63:32];
        5'h0C: bus_rdata = r_mtimecmp[31:0];
        5'h10: bus_rdata = r_mtimecmp[63:32];
`endif
        default: bus_rdata = '0;
      endcase
    end
  end

  // Fixed priority among enabled pending sources: MEI > MSI > MTI.
  assign w_irq     = r_mip & mie;
  assign w_irq_any = w_irq[11] | w_irq[7] | w_irq[3];
  assign w_code    = w_irq[11] ? 5'd11 : (w_irq[3] ? 5'd3 : 5'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_trap_pending <= 1'b0;
      r_trap_cause   <= '0;
      r_double_trap  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_trap_pending <= 1'b0;
          if (exc_valid) begin
            r_state        <= ISSUE;
            r_trap_pending <= 1'b1;
            r_trap_cause   <= {27'b0, exc_cause};
          end else if (irq_en && instr_boundary && w_irq_any) begin
            r_state        <= ISSUE;
            r_trap_pending <= 1'b1;
            r_trap_cause   <= {1'b1, 26'b0, w_code};
          end
        end
        ISSUE: begin
          r_state        <= IDLE;
          r_trap_pending <= 1'b0;
          if (exc_valid) r_double_trap <= 1'b1;
        end
        default: begin
          r_state        <= IDLE;
          r_trap_pending <= 1'b0;
        end
      endcase
    end
  end

  assign mip          = r_mip;
  assign trap_pending = r_trap_pending;
  assign trap_cause   = r_trap_cause;
  assign double_trap  = r_double_trap;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected trap causes are queued at stimulus time and a
// monitor pops them on every trap_pending pulse; register/flag checks are made inline.
module tb_irq_ctrl;
  localparam int SYNC_STAGES = 2;
  localparam int TIMER_DIV   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_ext = 1'b0;
  logic        instr_boundary = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] mie = '0;
  logic        irq_en = 1'b0;
  logic [31:0] mip;
  logic        trap_pending;
  logic [31:0] trap_cause;
  logic        double_trap;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_tp = 1'b0;

  irq_ctrl #(.SYNC_STAGES(SYNC_STAGES), .TIMER_DIV(TIMER_DIV)) dut (
    .clk(clk), .rst(rst), .irq_ext(irq_ext), .instr_boundary(instr_boundary),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .mie(mie), .irq_en(irq_en),
    .mip(mip), .trap_pending(trap_pending), .trap_cause(trap_cause),
    .double_trap(double_trap), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: every trap pulse must match the head of the expected queue, and last one cycle
  always @(posedge clk) begin
    #1;
    if (trap_pending) begin
      n_checks++;
      if (prev_tp) begin
        n_errors++;
        $display("FAIL pulse_width: trap_pending high two cycles, cause=%h", trap_cause);
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_trap: got cause=%h, none expected", trap_cause);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (trap_cause !== e) begin
          n_errors++;
          $display("FAIL trap_cause: got %h, expected %h", trap_cause, e);
        end
      end
    end
    prev_tp = trap_pending;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = addr;
    #1;
    check(name, bus_rdata, exp);
    bus_sel = 1'b0;
  endtask

  initial begin
    // reset values (checked while rst is still held)
    tick(2);
    check("rst_trap_pending", {31'b0, trap_pending}, 32'd0);
    check("rst_trap_cause", trap_cause, 32'd0);
    check("rst_mip", mip, 32'd0);
    check("rst_double_trap", {31'b0, double_trap}, 32'd0);
    bus_read_check("rst_msip", 5'h00, 32'd0);
`ifdef IRQ_CTRL_TIMER_EN
    bus_read_check("rst_mtime_lo", 5'h04, 32'd0);
    bus_read_check("rst_mtimecmp_lo", 5'h0C, 32'hFFFF_FFFF);
    bus_read_check("rst_mtimecmp_hi", 5'h10, 32'hFFFF_FFFF);
`else
    bus_read_check("rst_mtimecmp_lo_off", 5'h0C, 32'd0);
`endif
    rst = 1'b0;
    tick(2);

    // 1: external interrupt, SYNC_STAGES+2 edges to the pulse
    mie = 32'h800; irq_en = 1'b1; instr_boundary = 1'b1; irq_ext = 1'b1;
    exp_q.push_back(32'h8000_000B);
    tick(SYNC_STAGES + 1);
    check("mei_not_yet", {31'b0, trap_pending}, 32'd0);
    check("mei_mip", mip, 32'h800);
    tick(1);
    check("mei_pulse", {31'b0, trap_pending}, 32'd1);
    irq_en = 1'b0; irq_ext = 1'b0;
    tick(1);
    check("mei_pulse_end", {31'b0, trap_pending}, 32'd0);
    check("cause_held", trap_cause, 32'h8000_000B);
    tick(5);
    check("mei_cleared", mip, 32'd0);

    // 5: pending MEI masked by irq_en, then by instr_boundary
    instr_boundary = 1'b0; irq_ext = 1'b1;
    tick(6);
    check("masked_mip", mip, 32'h800);
    irq_en = 1'b1;
    tick(3);
    check("no_boundary", {31'b0, trap_pending}, 32'd0);
    exp_q.push_back(32'h8000_000B);
    instr_boundary = 1'b1;
    tick(1);
    check("boundary_pulse", {31'b0, trap_pending}, 32'd1);
    irq_en = 1'b0;
    tick(2);

    // 2: exception beats a simultaneous enabled MEI
    irq_en = 1'b1; exc_valid = 1'b1; exc_cause = 5'd2;
    exp_q.push_back(32'h0000_0002);
    tick(1);
    check("exc_pulse", {31'b0, trap_pending}, 32'd1);
    exc_valid = 1'b0; irq_en = 1'b0;
    tick(1);
    check("exc_one_pulse", {31'b0, trap_pending}, 32'd0);
    irq_ext = 1'b0; instr_boundary = 1'b0;
    tick(5);
    check("exc_no_double", {31'b0, double_trap}, 32'd0);

    // 3: software interrupt beats timer; then timer after msip cleared
    mie = 32'h888;
    bus_write(5'h00, 32'h1);
    bus_write(5'h0C, 32'h0);
    bus_write(5'h10, 32'h0);
    tick(2);
    bus_read_check("msip_read", 5'h00, 32'd1);
`ifdef IRQ_CTRL_TIMER_EN
    check("sw_tm_mip", mip, 32'h088);
`else
    check("sw_mip_off", mip, 32'h008);
`endif
    exp_q.push_back(32'h8000_0003);
    irq_en = 1'b1; instr_boundary = 1'b1;
    tick(1);
    check("msi_pulse", {31'b0, trap_pending}, 32'd1);
    irq_en = 1'b0;
    tick(1);
    bus_write(5'h00, 32'h0);
    tick(2);
`ifdef IRQ_CTRL_TIMER_EN
    check("tm_only_mip", mip, 32'h080);
    exp_q.push_back(32'h8000_0007);
    irq_en = 1'b1;
    tick(1);
    check("mti_pulse", {31'b0, trap_pending}, 32'd1);
    irq_en = 1'b0;
    tick(2);
`else
    check("no_tm_mip", mip, 32'h000);
    irq_en = 1'b1;
    tick(3);
    irq_en = 1'b0;
`endif
    instr_boundary = 1'b0; mie = 32'h0;

    // 4: timer compare edge and 64-bit wrap
`ifdef IRQ_CTRL_TIMER_EN
    bus_write(5'h0C, 32'h20);
    bus_write(5'h08, 32'h0);
    bus_write(5'h04, 32'h0);
    tick(32);
    bus_read_check("mtime_at_cmp", 5'h04, 32'h20);
    check("mtip_lag", {31'b0, mip[7]}, 32'd0);
    tick(1);
    check("mtip_rise", {31'b0, mip[7]}, 32'd1);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    bus_read_check("mtime_max_lo", 5'h04, 32'hFFFF_FFFF);
    bus_read_check("mtime_max_hi", 5'h08, 32'hFFFF_FFFF);
    tick(1);
    bus_read_check("wrap_lo", 5'h04, 32'h0);
    bus_read_check("wrap_hi", 5'h08, 32'h0);
`else
    bus_write(5'h04, 32'h1234_5678);
    tick(1);
    bus_read_check("off_mtime_lo", 5'h04, 32'd0);
    bus_read_check("off_mtime_hi", 5'h08, 32'd0);
    bus_read_check("off_mtimecmp_hi", 5'h10, 32'd0);
`endif
    bus_write(5'h14, 32'hFFFF_FFFF);
    bus_read_check("bad_offset", 5'h14, 32'd0);
    bus_read_check("msip_cleared", 5'h00, 32'd0);

    // 6: exception during ISSUE sets sticky double_trap; reset mid-pulse
    exc_valid = 1'b1; exc_cause = 5'd5;
    exp_q.push_back(32'h0000_0005);
    tick(1);
    exc_cause = 5'd6;
    tick(1);
    exc_valid = 1'b0;
    check("dt_set", {31'b0, double_trap}, 32'd1);
    check("dt_no_second", {31'b0, trap_pending}, 32'd0);
    tick(4);
    check("dt_sticky", {31'b0, double_trap}, 32'd1);
    check("dt_cause_held", trap_cause, 32'h0000_0005);
    exc_valid = 1'b1; exc_cause = 5'd7;
    exp_q.push_back(32'h0000_0007);
    tick(1);
    check("rst_mid_pulse", {31'b0, trap_pending}, 32'd1);
    exc_valid = 1'b0; rst = 1'b1;
    tick(1);
    check("rst_drop_tp", {31'b0, trap_pending}, 32'd0);
    check("rst_drop_dt", {31'b0, double_trap}, 32'd0);
    check("rst_drop_cause", trap_cause, 32'd0);
    rst = 1'b0;
    tick(3);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
